// File: rtl/flash_id_uart_report.sv
// rtl/flash_id_uart_report.sv - captures a JEDEC ID and reports "HHHHHH OK|NG\r\n" over UART 8N1
module flash_id_uart_report #(
   parameter int          CLK_FREQ = 50_000_000,
   parameter int          BAUD     = 115200,
   parameter logic [23:0] EXP_ID   = 24'hEF4017
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [23:0] flash_id,
   input  logic        valid_id,
   output logic        uart_tx,
   output logic        busy,
   output logic        id_match,
   output logic        done
);
   localparam int               BAUD_DIV = CLK_FREQ / BAUD;
   localparam int               CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [3:0]       byte_idx, byte_idx_n;
   logic             tx_n;
   logic             valid_q;
   logic [23:0]      id_reg;
   logic [7:0]       cur_byte;
   logic             capture;
   logic             bit_end;

   function automatic logic [7:0] hex(input logic [3:0] n);
      return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   always_comb begin
      cur_byte = 8'h0A;
      case (byte_idx)
         4'd0:    cur_byte = hex(id_reg[23:20]);
         4'd1:    cur_byte = hex(id_reg[19:16]);
         4'd2:    cur_byte = hex(id_reg[15:12]);
         4'd3:    cur_byte = hex(id_reg[11:8]);
         4'd4:    cur_byte = hex(id_reg[7:4]);
         4'd5:    cur_byte = hex(id_reg[3:0]);
         4'd6:    cur_byte = 8'h20;
         4'd7:    cur_byte = id_match ? 8'h4F : 8'h4E;
         4'd8:    cur_byte = id_match ? 8'h4B : 8'h47;
         4'd9:    cur_byte = 8'h0D;
         default: cur_byte = 8'h0A;
      endcase
   end

   // tx_n is the line level for the next cycle, so uart_tx comes straight from a flop
   always_comb begin
      capture    = (state == IDLE) && valid_id && !valid_q;
      bit_end    = (baud_cnt == CNT_LAST);
      state_n    = state;
      baud_cnt_n = baud_cnt + 1'b1;
      bit_idx_n  = bit_idx;
      byte_idx_n = byte_idx;
      tx_n       = uart_tx;
      case (state)
         IDLE: begin
            baud_cnt_n = '0;
            tx_n       = 1'b1;
            if (capture) begin
               state_n    = START;
               byte_idx_n = 4'd0;
               tx_n       = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_n    = DATA;
               baud_cnt_n = '0;
               bit_idx_n  = 3'd0;
               tx_n       = cur_byte[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_cnt_n = '0;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
                  tx_n      = cur_byte[bit_idx + 3'd1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_cnt_n = '0;
               if (byte_idx < 4'd10) begin
                  state_n    = START;
                  byte_idx_n = byte_idx + 4'd1;
                  tx_n       = 1'b0;
               end else begin
                  state_n = DONE;
                  tx_n    = 1'b1;
               end
            end
         end
         DONE: begin
            state_n    = IDLE;
            baud_cnt_n = '0;
         end
         default: begin
            state_n    = IDLE;
            baud_cnt_n = '0;
            tx_n       = 1'b1;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         byte_idx <= 4'd0;
         uart_tx  <= 1'b1;
         valid_q  <= 1'b0;
         id_reg   <= 24'd0;
         id_match <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_cnt_n;
         bit_idx  <= bit_idx_n;
         byte_idx <= byte_idx_n;
         uart_tx  <= tx_n;
         valid_q  <= valid_id;
         if (capture) begin
            id_reg   <= flash_id;
            id_match <= (flash_id == EXP_ID);
         end
      end
   end

   assign busy = (state != IDLE) && (state != DONE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_flash_id_uart_report.sv
// tb/tb_flash_id_uart_report.sv - scoreboard bench for flash_id_uart_report with BAUD_DIV=10
module tb_flash_id_uart_report;
   logic        clk = 1'b0;
   logic        sys_rst;
   logic [23:0] flash_id;
   logic        valid_id;
   logic        uart_tx;
   logic        busy;
   logic        id_match;
   logic        done;

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic       match;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp    = 0;
   int   n_bad    = 0;
   int   done_cnt = 0;

   flash_id_uart_report #(
      .CLK_FREQ(1000),
      .BAUD    (100),
      .EXP_ID  (24'hEF4017)
   ) dut (
      .sys_clk (clk),
      .sys_rst (sys_rst),
      .flash_id(flash_id),
      .valid_id(valid_id),
      .uart_tx (uart_tx),
      .busy    (busy),
      .id_match(id_match),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // The nine printable characters come from the vector string; CR LF are appended
   task automatic push_report(input string s, input logic m);
      exp_t e;
      for (int i = 0; i < s.len(); i++) begin
         e.data = s[i]; e.last = 1'b0; e.match = m;
         exp_q.push_back(e);
      end
      e.data = 8'h0D; e.last = 1'b0; e.match = m;
      exp_q.push_back(e);
      e.data = 8'h0A; e.last = 1'b1; e.match = m;
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < budget);
      check("done_seen", {31'd0, done}, 32'd1);
   endtask

   task automatic pulse_id(input logic [23:0] id);
      @(posedge clk); #1;
      flash_id = id;
      valid_id = 1'b1;
      @(posedge clk); #1;
      valid_id = 1'b0;
   endtask

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   // Monitor: every sample of every bit is compared with the expected frame level
   initial begin : monitor
      exp_t       item;
      logic [9:0] frame;
      logic [7:0] rx;
      int         bad_samples;
      bit         have_start;
      bit         aborted;
      have_start = 0;
      forever begin
         if (!have_start) begin
            @(negedge clk);
            if (sys_rst !== 1'b0 || uart_tx !== 1'b0) continue;
         end
         have_start = 0;
         if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
            repeat (100) @(negedge clk);
            continue;
         end
         item        = exp_q.pop_front();
         frame       = {1'b1, item.data, 1'b0};
         rx          = 8'h00;
         bad_samples = 0;
         aborted     = 0;
         for (int i = 0; i < 100; i++) begin
            if (i > 0) @(negedge clk);
            if (sys_rst !== 1'b0) begin
               aborted = 1;
               break;
            end
            if (uart_tx !== frame[i / 10]) bad_samples++;
            if ((i % 10) == 5 && i >= 10 && i < 90) rx[i / 10 - 1] = uart_tx;
         end
         if (aborted) continue;
         check("bit_timing", bad_samples, 0);
         check("rx_byte", {24'd0, rx}, {24'd0, item.data});
         @(negedge clk);
         if (sys_rst !== 1'b0) continue;
         if (!item.last) begin
            check("no_gap", {31'd0, uart_tx}, 32'd0);
            if (uart_tx === 1'b0) have_start = 1;
         end else begin
            check("done_after_stop", {31'd0, done}, 32'd1);
            check("busy_at_done", {31'd0, busy}, 32'd0);
            check("id_match", {31'd0, id_match}, {31'd0, item.match});
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      sys_rst  = 1'b1;
      flash_id = 24'd0;
      valid_id = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_id_match", {31'd0, id_match}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      sys_rst = 1'b0;
      repeat (3) @(posedge clk);

      // T1: matching ID
      push_report("EF4017 OK", 1'b1);
      pulse_id(24'hEF4017);
      check("t1_busy_n1", {31'd0, busy}, 32'd1);
      check("t1_tx_fall_n1", {31'd0, uart_tx}, 32'd0);
      wait_done(1200);
      repeat (5) @(posedge clk);

      // T2: all-zero ID
      push_report("000000 NG", 1'b0);
      pulse_id(24'h000000);
      wait_done(1200);
      repeat (5) @(posedge clk);

      // T3: valid_id held high far longer than one report
      push_report("ABCDEF NG", 1'b0);
      @(posedge clk); #1;
      flash_id = 24'hABCDEF;
      valid_id = 1'b1;
      repeat (5000) @(posedge clk);
      #1;
      valid_id = 1'b0;
      check("t3_busy_low", {31'd0, busy}, 32'd0);
      repeat (5) @(posedge clk);

      // T4: second edge mid-report and an edge on the DONE cycle are both ignored
      push_report("123456 NG", 1'b0);
      pulse_id(24'h123456);
      repeat (330) @(posedge clk);
      #1;
      flash_id = 24'hEF4017;
      valid_id = 1'b1;
      @(posedge clk); #1;
      valid_id = 1'b0;
      check("t4_busy_mid", {31'd0, busy}, 32'd1);
      wait_done(1200);
      valid_id = 1'b1;
      @(negedge clk);
      valid_id = 1'b0;
      repeat (50) @(negedge clk);
      check("t4_idle_busy", {31'd0, busy}, 32'd0);
      check("t4_idle_tx", {31'd0, uart_tx}, 32'd1);

      // T5: asynchronous reset during data bits of byte 5, then a fresh report
      push_report("EF4017 OK", 1'b1);
      pulse_id(24'hEF4017);
      repeat (540) @(posedge clk);
      #1;
      sys_rst = 1'b1;
      #1;
      check("t5_rst_tx", {31'd0, uart_tx}, 32'd1);
      check("t5_rst_busy", {31'd0, busy}, 32'd0);
      check("t5_rst_id_match", {31'd0, id_match}, 32'd0);
      flash_id = 24'h00A5F9;
      valid_id = 1'b1;
      repeat (3) @(posedge clk);
      exp_q.delete();
      push_report("00A5F9 NG", 1'b0);
      #1;
      sys_rst = 1'b0;
      wait_done(1300);
      valid_id = 1'b0;
      repeat (20) @(posedge clk);

      check("leftover_expected", exp_q.size(), 0);
      check("done_pulses", done_cnt, 5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
